// File: rtl/uart_pkg.sv
// Shared UART definitions: config word layout, parity/stop encodings and transmit states.
package uart_pkg;

  localparam int unsigned CFG_W    = 27;
  localparam int unsigned DATA_W   = 9;
  localparam int unsigned PRESC_W  = 16;
  localparam int unsigned PARITY_W = 3;
  localparam int unsigned BSIZE_W  = 4;

  localparam int unsigned PRESC_LSB  = 0;
  localparam int unsigned PARITY_LSB = 16;
  localparam int unsigned BSIZE_LSB  = 19;
  localparam int unsigned STOP_BIT   = 23;
  localparam int unsigned EN_BIT     = 24;

  localparam logic [PARITY_W-1:0] PARITY_NONE  = 3'd0;
  localparam logic [PARITY_W-1:0] PARITY_EVEN  = 3'd1;
  localparam logic [PARITY_W-1:0] PARITY_ODD   = 3'd2;
  localparam logic [PARITY_W-1:0] PARITY_MARK  = 3'd3;
  localparam logic [PARITY_W-1:0] PARITY_SPACE = 3'd4;

  localparam logic STOP_BITS_ONE = 1'b0;
  localparam logic STOP_BITS_TWO = 1'b1;

  localparam logic [BSIZE_W-1:0] BSIZE_MIN = 4'd5;
  localparam logic [BSIZE_W-1:0] BSIZE_MAX = 4'd9;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_e;

  // Out-of-range frame sizes snap to the nearest legal size.
  function automatic logic [BSIZE_W-1:0] clamp_bsize(input logic [BSIZE_W-1:0] b);
    if (b < BSIZE_MIN) return BSIZE_MIN;
    if (b > BSIZE_MAX) return BSIZE_MAX;
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] data_mask(input logic [BSIZE_W-1:0] b);
    return DATA_W'((10'd1 << b) - 10'd1);
  endfunction

endpackage

// File: rtl/uart_tx_bitclk.sv
// Bit-period timer: reloads every bit boundary; prescaler values below 2 run as 2.
module uart_tx_bitclk
  import uart_pkg::*;
(
  input  logic               aclk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescaler,
  output logic               bit_end_c,
  output logic               pre_end_c
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] period_c;

  assign period_c  = (prescaler < PRESC_W'(2)) ? PRESC_W'(2) : prescaler;
  assign bit_end_c = en & (cnt == PRESC_W'(1));
  assign pre_end_c = en & (cnt == PRESC_W'(2));

  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period_c;
    end else if (en) begin
      cnt <= bit_end_c ? period_c : cnt - PRESC_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, MSB-first data, optional parity, 1/2 stop bits, CTS-gated frame start.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_PRESCALER = 12,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned STOP_BITS      = 0
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic [CFG_W-1:0]  s_axis_config_tdata,
  input  logic              s_axis_config_tvalid,
  output logic              s_axis_config_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              busy,
  output logic              tx_done,
  output logic              txd,
  input  logic              ctsn
);

  logic [PRESC_W-1:0]  cfg_presc;
  logic [PARITY_W-1:0] cfg_parity;
  logic [BSIZE_W-1:0]  cfg_bsize;
  logic                cfg_stop;
  logic                cfg_en;

  tx_state_e           state;
  logic                ctsn_q;
  logic [DATA_W-1:0]   shreg;
  logic [BSIZE_W-1:0]  bits_left;
  logic                par_en;
  logic                par_bit;
  logic                stop_left;

  logic                cfg_fire_c;
  logic                data_fire_c;
  logic                bit_end_c;
  logic                pre_end_c;
  logic [BSIZE_W-1:0]  bsize_eff_c;
  logic [DATA_W-1:0]   word_c;
  logic                par_sel_c;
  logic                par_en_c;
  logic                unused_cfg;

  assign unused_cfg = ^s_axis_config_tdata[CFG_W-1:EN_BIT+1];

  assign s_axis_config_tready = (state == TX_IDLE) & ~rst;
  assign s_axis_tready        = (state == TX_IDLE) & cfg_en & ~ctsn_q
                              & ~s_axis_config_tvalid & ~rst;
  assign cfg_fire_c  = s_axis_config_tvalid & s_axis_config_tready;
  assign data_fire_c = s_axis_tvalid & s_axis_tready;

  // Frame parameters derived from the live config at the moment of accept.
  always_comb begin
    bsize_eff_c = clamp_bsize(cfg_bsize);
    word_c      = s_axis_tdata & data_mask(bsize_eff_c);
    par_en_c    = (cfg_parity != PARITY_NONE) && (cfg_parity <= PARITY_SPACE);
    par_sel_c   = 1'b0;
    case (cfg_parity)
      PARITY_EVEN:  par_sel_c = ^word_c;
      PARITY_ODD:   par_sel_c = ~(^word_c);
      PARITY_MARK:  par_sel_c = 1'b1;
      PARITY_SPACE: par_sel_c = 1'b0;
      default:      par_sel_c = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      cfg_presc  <= PRESC_W'(BAUD_PRESCALER);
      cfg_parity <= PARITY_W'(PARITY);
      cfg_bsize  <= BSIZE_W'(BYTE_SIZE);
      cfg_stop   <= (STOP_BITS != 0) ? STOP_BITS_TWO : STOP_BITS_ONE;
      cfg_en     <= 1'b1;
    end else if (cfg_fire_c) begin
      cfg_presc  <= s_axis_config_tdata[PRESC_LSB +: PRESC_W];
      cfg_parity <= s_axis_config_tdata[PARITY_LSB +: PARITY_W];
      cfg_bsize  <= s_axis_config_tdata[BSIZE_LSB +: BSIZE_W];
      cfg_stop   <= s_axis_config_tdata[STOP_BIT];
      cfg_en     <= s_axis_config_tdata[EN_BIT];
    end
  end

  // CTS is sampled once at the pad; reset treats the line as not clear.
  always_ff @(posedge aclk) begin
    if (rst) ctsn_q <= 1'b1;
    else     ctsn_q <= ctsn;
  end

  uart_tx_bitclk u_bitclk (
    .aclk      (aclk),
    .rst       (rst),
    .load      (data_fire_c),
    .en        (state != TX_IDLE),
    .prescaler (cfg_presc),
    .bit_end_c (bit_end_c),
    .pre_end_c (pre_end_c)
  );

  // Frame sequencer; data is left-aligned so shreg[MSB] is always the next bit out.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state     <= TX_IDLE;
      txd       <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop_left <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (data_fire_c) begin
            state     <= TX_START;
            txd       <= 1'b0;
            busy      <= 1'b1;
            shreg     <= word_c << (BSIZE_W'(DATA_W) - bsize_eff_c);
            bits_left <= bsize_eff_c;
            par_en    <= par_en_c;
            par_bit   <= par_sel_c;
            stop_left <= cfg_stop;
          end
        end
        TX_START: begin
          if (bit_end_c) begin
            state     <= TX_DATA;
            txd       <= shreg[DATA_W-1];
            shreg     <= shreg << 1;
            bits_left <= bits_left - BSIZE_W'(1);
          end
        end
        TX_DATA: begin
          if (bit_end_c) begin
            if (bits_left != '0) begin
              txd       <= shreg[DATA_W-1];
              shreg     <= shreg << 1;
              bits_left <= bits_left - BSIZE_W'(1);
            end else if (par_en) begin
              state <= TX_PAR;
              txd   <= par_bit;
            end else begin
              state <= TX_STOP;
              txd   <= 1'b1;
            end
          end
        end
        TX_PAR: begin
          if (bit_end_c) begin
            state <= TX_STOP;
            txd   <= 1'b1;
          end
        end
        TX_STOP: begin
          // Raise tx_done so it lands on the final cycle of the last stop bit.
          if (pre_end_c && !stop_left) tx_done <= 1'b1;
          if (bit_end_c) begin
            if (stop_left) begin
              stop_left <= 1'b0;
            end else begin
              state <= TX_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= TX_IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frames are checked cycle by cycle against a bit-list model.
module tb_uart_tx_core;

  logic        aclk = 1'b0;
  logic        rst;
  logic [26:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [8:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        tx_done;
  logic        txd;
  logic        ctsn;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  uart_tx_core dut (
    .aclk                 (aclk),
    .rst                  (rst),
    .s_axis_config_tdata  (cfg_data),
    .s_axis_config_tvalid (cfg_valid),
    .s_axis_config_tready (cfg_ready),
    .s_axis_tdata         (tdata),
    .s_axis_tvalid        (tvalid),
    .s_axis_tready        (tready),
    .busy                 (busy),
    .tx_done              (tx_done),
    .txd                  (txd),
    .ctsn                 (ctsn)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [26:0] cfg_word(input int p, input int par, input int bs, input int st);
    return {2'b00, 1'b1, 1'(st), 4'(bs), 3'(par), 16'(p)};
  endfunction

  task automatic send_cfg(input logic [26:0] w);
    int ok = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (cfg_ready === 1'b1) begin ok = 1; break; end
    end
    chk("cfg_accept", ok, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Leaves the bench at the first cycle of the start bit.
  task automatic send_data(input string tag, input logic [8:0] w, input bit keep);
    int ok = 0;
    tdata  = w;
    tvalid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (tready === 1'b1) begin ok = 1; break; end
    end
    chk({tag, "_accept"}, ok, 1);
    tick();
    if (!keep) tvalid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [8:0] w, input int p, input int bs,
                             input int par, input int stops, input int cts_at);
    logic q[$];
    int   pe, bsc, cyc, done_at, done_cnt, busy_bad;
    logic xr;
    pe  = (p < 2) ? 2 : p;
    bsc = (bs < 5) ? 5 : (bs > 9) ? 9 : bs;
    q.push_back(1'b0);
    xr = 1'b0;
    for (int i = bsc - 1; i >= 0; i--) begin
      q.push_back(w[i]);
      xr ^= w[i];
    end
    case (par)
      1: q.push_back(xr);
      2: q.push_back(~xr);
      3: q.push_back(1'b1);
      4: q.push_back(1'b0);
      default: ;
    endcase
    for (int i = 0; i <= stops; i++) q.push_back(1'b1);
    cyc = 0; done_at = -1; done_cnt = 0; busy_bad = 0;
    foreach (q[b]) begin
      int bad = 0;
      for (int c = 0; c < pe; c++) begin
        if (txd !== q[b]) bad++;
        if (busy !== 1'b1) busy_bad++;
        if (tx_done === 1'b1) begin
          done_cnt++;
          if (done_at < 0) done_at = cyc;
        end
        if (cyc == cts_at) ctsn = 1'b1;
        cyc++;
        tick();
      end
      chk($sformatf("%s_bit%0d", tag, b), bad, 0);
    end
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_done_at"}, done_at, pe * q.size() - 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_txd_end"}, int'(txd), 1);
  endtask

  initial begin
    int   bad;
    int   rdy_seen;
    time  t0;
    rst = 1'b1; cfg_data = '0; cfg_valid = 1'b0; tdata = '0; tvalid = 1'b0; ctsn = 1'b0;
    repeat (3) tick();
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_tready", int'(tready), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_cfg_ready", int'(cfg_ready), 1);

    // Default 8N1 at P=12.
    send_data("t1", 9'h0A5, 1'b0);
    check_frame("t1", 9'h0A5, 12, 8, 0, 0, -1);

    // P=4, even parity, 7 bits, two stop bits (44 clocks).
    send_cfg(cfg_word(4, 1, 7, 1));
    send_data("t2", 9'h055, 1'b0);
    check_frame("t2", 9'h055, 4, 7, 1, 1, -1);

    // CTS holds off a pending word, then release and raise mid-frame.
    ctsn = 1'b1;
    tick();
    tick();
    tdata = 9'h03C; tvalid = 1'b1; bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (tready !== 1'b0 || txd !== 1'b1) bad++;
    end
    chk("cts_block", bad, 0);
    tick();
    ctsn = 1'b0;
    tick();
    chk("cts_lat1", int'(txd), 1);
    tick();
    chk("cts_lat2", int'(txd), 0);
    tvalid = 1'b0;
    check_frame("t3", 9'h03C, 4, 7, 1, 1, 20);
    ctsn = 1'b0;
    tick();

    // Prescaler 1 runs as 2; byte size 3 runs as 5; odd parity.
    send_cfg(cfg_word(1, 2, 3, 0));
    send_data("t4", 9'h01B, 1'b0);
    check_frame("t4", 9'h01B, 1, 3, 2, 0, -1);

    // Three words back to back at P=2 8N1.
    send_cfg(cfg_word(2, 0, 8, 0));
    send_data("b2b0", 9'h081, 1'b1);
    t0 = $time;
    tdata = 9'h042;
    check_frame("b2b0", 9'h081, 2, 8, 0, 0, -1);
    chk("b2b_rdy1", int'(tready), 1);
    tick();
    tdata = 9'h0E7;
    check_frame("b2b1", 9'h042, 2, 8, 0, 0, -1);
    chk("b2b_rdy2", int'(tready), 1);
    tick();
    tvalid = 1'b0;
    chk("b2b_spacing", int'(($time - t0) / 10), 42);
    check_frame("b2b2", 9'h0E7, 2, 8, 0, 0, -1);

    // Config and data presented together: config first.
    cfg_data = cfg_word(3, 3, 6, 0); cfg_valid = 1'b1;
    tdata = 9'h02D; tvalid = 1'b1;
    @(negedge aclk);
    chk("cd_cfg_rdy", int'(cfg_ready), 1);
    chk("cd_data_held", int'(tready), 0);
    tick();
    cfg_valid = 1'b0;
    @(negedge aclk);
    chk("cd_data_rdy", int'(tready), 1);
    tick();
    tvalid = 1'b0;
    check_frame("t6", 9'h02D, 3, 6, 3, 0, -1);

    // Reset during the third data bit abandons the frame.
    send_data("t7", 9'h1FF, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("mrst_txd", int'(txd), 1);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_tready", int'(tready), 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_done !== 1'b0 || txd !== 1'b1) bad++;
      tick();
    end
    chk("mrst_quiet", bad, 0);
    send_data("t8", 9'h00F, 1'b0);
    check_frame("t8", 9'h00F, 12, 8, 0, 0, -1);

    // Random configurations decoded by the frame model.
    for (int k = 0; k < 12; k++) begin
      int p, par, bs, st;
      logic [8:0] w;
      p = $urandom_range(4, 16); par = $urandom_range(0, 7);
      bs = $urandom_range(5, 9); st = $urandom_range(0, 1);
      w = 9'($urandom);
      send_cfg(cfg_word(p, par, bs, st));
      send_data($sformatf("rnd%0d", k), w, 1'b0);
      check_frame($sformatf("rnd%0d", k), w, p, bs, par, st, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Backstop so a stuck run still ends with a report.
  initial begin
    rdy_wait_guard();
  end

  task automatic rdy_wait_guard();
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  endtask

endmodule
